io_bus_master: RTL
==================

// Module: io_bus_master
// PURPOSE
// Initiator side of the MMIO I/O bus: bridges the CPU load/store port onto
// bus_cs/bus_wr/bus_rd/bus_addr/bus_wr_data and returns bus_rd_data.
// Range-checks, converts to word offsets, issues single-cycle strobes,
// waits a fixed read latency, and buffers one response until the CPU takes it.
// PARAMETERS
// BASE_ADDR   32'hC000_0000  byte base of the I/O window (2^ADDR_WIDTH-aligned)
// ADDR_WIDTH  11             window span = 2^ADDR_WIDTH bytes (16 slots x 32 regs x 4 B)
// RD_LATENCY  1              cycles from bus_rd strobe to valid bus_rd_data (>=1)
// PORTS
// clk          in   1   system clock, rising edge
// reset        in   1   asynchronous, active-low reset (0 = reset)
// req_valid    in   1   CPU request valid
// req_ready    out  1   request accepted when req_valid & req_ready
// req_we       in   1   1 = store, 0 = load
// req_addr     in   32  byte address
// req_be       in   4   byte enables
// req_wdata    in   32  store data
// rsp_valid    out  1   response valid; held until rsp_ready
// rsp_ready    in   1   CPU consumes response
// rsp_rdata    out  32  load data (0 for stores and errors)
// rsp_err      out  1   access fault
// bus_cs       out  1   bus select strobe
// bus_wr       out  1   bus write strobe
// bus_rd       out  1   bus read strobe
// bus_addr     out  32  word offset = (req_addr-BASE_ADDR)>>2, upper bits 0
// bus_wr_data  out  32  write data
// bus_rd_data  in   32  read data from I/O controller
// BEHAVIOUR
// - Reset (async, reset=0): state IDLE; req_ready=0 while in reset, 1 in IDLE
//   after release. rsp_valid, rsp_err, bus_cs/wr/rd = 0. rsp_rdata, bus_addr,
//   bus_wr_data = 0. Reset mid-operation drops any strobe immediately; the
//   pending request is lost and no response is produced.
// - FSM states: IDLE, WR, RD, RD_WAIT, RESP. req_ready = (state==IDLE).
// - IDLE, accept: latch addr/we/be/wdata. Error if any of:
//   req_addr outside [BASE_ADDR, BASE_ADDR+2^ADDR_WIDTH), req_addr[1:0]!=0,
//   or (req_we && req_be!=4'hF). The bus has no byte lanes.
//   Error -> RESP with rsp_err=1, rsp_rdata=0, no bus strobe.
//   OK store -> WR; OK load -> RD. Load req_be is ignored and the full word is returned.
// - WR: bus_cs=bus_wr=1 for exactly this one cycle. -> RESP with rsp_err=0, rdata=0.
// - RD: bus_cs=bus_rd=1 for exactly this one cycle. Latency counter loads RD_LATENCY-1.
//   RD_LATENCY=1 -> RESP, capturing bus_rd_data on this edge.
//   Otherwise -> RD_WAIT.
// - RD_WAIT: no strobes. Counter decrements. At 0, capture bus_rd_data -> RESP.
// - RESP: rsp_valid=1 with stable rdata/err. On rsp_ready -> IDLE.
//   A new request is accepted no earlier than the cycle after the handshake.
// - Strobes are registered outputs. They are never high two consecutive cycles
//   and never high outside WR/RD, so FIFO-pop registers see one pulse per access.
// - bus_addr/bus_wr_data hold their last value when idle.
// - Latency, accept at edge T, rsp_ready tied 1:
//   store: strobe cycle T+1, rsp_valid cycle T+2.
//   load: strobe T+1, data sampled end of T+RD_LATENCY, rsp_valid T+RD_LATENCY+1.
//   error: rsp_valid T+1.
// - Range check uses full 32-bit compare. BASE_ADDR+2^ADDR_WIDTH wrapping past
//   2^32 is a parameter error (elaboration assertion).
// TESTING
// 1. Store 0xC000_0004, be=F, wdata=0xDEADBEEF -> one-cycle bus_cs&bus_wr,
//    bus_addr=1, bus_wr_data=0xDEADBEEF; rsp_valid next cycle, err=0.
// 2. Load 0xC000_0080 (RD_LATENCY=1 and 3), model returns 0x1234_5678 ->
//    exactly one bus_rd pulse, bus_addr=0x20, rsp_rdata=0x1234_5678 at stated latency.
// 3. Faults: load 0xC000_0800, store be=4'h3, load 0xC000_0002 ->
//    rsp_err=1, rdata=0, bus_cs never asserted.
// 4. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0,
//    a second req_valid not accepted; accepted the cycle after the handshake.
// 5. Assert reset during RD_WAIT -> strobes/rsp_valid 0 immediately.
//    After release, a fresh store completes normally with no stale response.
// 6. Back-to-back loads with rsp_ready=1 -> bus_rd never high on adjacent cycles.

Source files
------------

// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// io_bus_master : bridges the CPU load/store port onto the MMIO I/O bus
// Revision      : 1.0
// ============================================================================
module io_bus_master #(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0000,
  parameter int          ADDR_WIDTH = 11,
  parameter int          RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_cs,
  output logic        bus_wr,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data
);

  localparam int               CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [32:0]      WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [32:0]      WIN_HI   = WIN_LO + (33'd1 << ADDR_WIDTH);
  localparam logic [31:0]      OFF_MASK = (32'd1 << ADDR_WIDTH) - 32'd1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  if (WIN_HI > 33'h1_0000_0000) begin : g_window_wraps
    $error("io_bus_master: BASE_ADDR + 2**ADDR_WIDTH wraps past 2**32");
  end
  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("io_bus_master: RD_LATENCY must be at least 1");
  end
  if (ADDR_WIDTH < 3 || ADDR_WIDTH > 31) begin : g_bad_width
    $error("io_bus_master: ADDR_WIDTH out of range");
  end
  if ((BASE_ADDR & OFF_MASK) != 32'd0) begin : g_unaligned_base
    $error("io_bus_master: BASE_ADDR not aligned to the window size");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               bus_cs_q, bus_cs_d;
  logic               bus_wr_q, bus_wr_d;
  logic               bus_rd_q, bus_rd_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wr_data_q, bus_wr_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_in_range;
  logic               w_req_err;
  logic [31:0]        w_word_off;

  // 33-bit compare so a window ending exactly at 2^32 still checks correctly
  assign w_in_range = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
  assign w_req_err  = !w_in_range || (req_addr[1:0] != 2'b00) ||
                      (req_we && (req_be != 4'hF));
  assign w_word_off = ((req_addr - BASE_ADDR) & OFF_MASK) >> 2;

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    bus_cs_d      = 1'b0;
    bus_wr_d      = 1'b0;
    bus_rd_d      = 1'b0;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          if (w_req_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            bus_cs_d   = 1'b1;
            bus_addr_d = w_word_off;
            cnt_d      = CNT_LOAD;
            if (req_we) begin
              state_d       = S_WR;
              bus_wr_d      = 1'b1;
              bus_wr_data_d = req_wdata;
            end else begin
              state_d  = S_RD;
              bus_rd_d = 1'b1;
            end
          end
        end
      end
      S_WR: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
      end
      // The strobe cycle and the wait cycles share the countdown
      S_RD, S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = bus_rd_data;
        end else begin
          state_d = S_RD_WAIT;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
      bus_cs_q      <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_rd_q      <= 1'b0;
      bus_addr_q    <= 32'd0;
      bus_wr_data_q <= 32'd0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      bus_cs_q      <= bus_cs_d;
      bus_wr_q      <= bus_wr_d;
      bus_rd_q      <= bus_rd_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign bus_cs      = bus_cs_q;
  assign bus_wr      = bus_wr_q;
  assign bus_rd      = bus_rd_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule
`default_nettype wire
